// File: rtl/ldpc_pkg.sv
// Shared constants and types for the GF(257) 4x24 LDPC decoder.
package ldpc_pkg;

    localparam int unsigned NUM_COLS  = 24;
    localparam int unsigned GF_Q      = 257;
    localparam int unsigned SYM_WIDTH = 9;

    typedef logic [SYM_WIDTH-1:0] sym_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cpu_wr_ctrl_if.sv
// CPU symbol stream and column-memory write port of the CPU write loader.
interface cpu_wr_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned NUM_COLS   = 24
);

    logic                  cpu_on;
    logic                  cpu_wr_valid;
    logic [DATA_WIDTH-1:0] cpu_wr_data;
    logic                  cpu_wr_ready;
    logic [NUM_COLS-1:0]   wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  load_done;
    logic                  busy;
    logic                  sym_err;

    // CPU / host side
    modport master (
        output cpu_on, cpu_wr_valid, cpu_wr_data,
        input  cpu_wr_ready, wr_en, wr_addr, wr_data, load_done, busy, sym_err
    );

    // Loader side
    modport slave (
        input  cpu_on, cpu_wr_valid, cpu_wr_data,
        output cpu_wr_ready, wr_en, wr_addr, wr_data, load_done, busy, sym_err
    );

endinterface

// File: rtl/cpu_wr_cnt.sv
// Column/row counter pair for the write loader; column wraps into the row, and the
// row wraps at the frame end so it never exceeds NUM_ROWS-1.
module cpu_wr_cnt #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_COLS   = 24,
    parameter int unsigned NUM_ROWS   = 256,
    localparam int unsigned COL_WIDTH = $clog2(NUM_COLS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_inc,
    output logic [COL_WIDTH-1:0]  o_col,
    output logic [ADDR_WIDTH-1:0] o_row,
    output logic                  o_last
);

    logic [COL_WIDTH-1:0]  r_col;
    logic [ADDR_WIDTH-1:0] r_row;
    logic                  w_col_wrap;
    logic                  w_row_wrap;

    assign w_col_wrap = (r_col == COL_WIDTH'(NUM_COLS - 1));
    assign w_row_wrap = (r_row == ADDR_WIDTH'(NUM_ROWS - 1));
    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_last     = w_col_wrap & w_row_wrap;

    // Counter state: clear has priority over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_inc) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= w_row_wrap ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_wr_ctrl.sv
// CPU-side write loader: spreads a CPU symbol stream column-round-robin over the
// column memories and pulses load_done once a full frame is stored.
// Optional symbol range check enabled by defining CPU_WR_SYM_CHK_EN.
module cpu_wr_ctrl #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = ldpc_pkg::SYM_WIDTH,
    parameter int unsigned NUM_COLS   = ldpc_pkg::NUM_COLS,
    parameter int unsigned NUM_ROWS   = 256
) (
    input  logic         clk,
    input  logic         rst,
    cpu_wr_ctrl_if.slave bus
);

    import ldpc_pkg::*;

    localparam int unsigned COL_WIDTH = $clog2(NUM_COLS);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_ready;
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_clr;
    logic                  w_last;
    logic [COL_WIDTH-1:0]  w_col;
    logic [ADDR_WIDTH-1:0] w_row;
    logic [DATA_WIDTH-1:0] w_wr_data_nxt;
    logic                  w_sym_bad;

    logic [NUM_COLS-1:0]   r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_load_done;
    logic                  r_sym_err;

    cpu_wr_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_COLS   (NUM_COLS),
        .NUM_ROWS   (NUM_ROWS)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_inc  (w_accept),
        .o_col  (w_col),
        .o_row  (w_row),
        .o_last (w_last)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, handshake and counter clear; cpu_on low aborts from any state
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_clr       = 1'b1;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.cpu_on) w_state_nxt = LOAD;
            end
            LOAD: begin
                w_busy   = 1'b1;
                w_ready  = bus.cpu_on;
                w_clr    = ~bus.cpu_on;
                w_accept = bus.cpu_wr_valid & w_ready;
                if (!bus.cpu_on) begin
                    w_state_nxt = IDLE;
                end else if (w_accept && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (!bus.cpu_on) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Symbol range check: values above GF_Q-1 are not field elements
    always_comb begin
        w_sym_bad     = 1'b0;
        w_wr_data_nxt = bus.cpu_wr_data;
`ifdef CPU_WR_SYM_CHK_EN
        w_sym_bad = (bus.cpu_wr_data > DATA_WIDTH'(GF_Q - 1));
        if (w_sym_bad) w_wr_data_nxt = '0;
`endif
    end

    // Registered write port; address/data hold when no beat is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en     <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_wr_en     <= w_accept ? (NUM_COLS'(1) << w_col) : '0;
            r_load_done <= w_accept & w_last;
            if (w_accept) begin
                r_wr_addr <= w_row;
                r_wr_data <= w_wr_data_nxt;
            end
        end
    end

`ifdef CPU_WR_SYM_CHK_EN
    // Sticky error, cleared only when a new session starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sym_err <= 1'b0;
        end else if (r_state == IDLE && bus.cpu_on) begin
            r_sym_err <= 1'b0;
        end else if (w_accept && w_sym_bad) begin
            r_sym_err <= 1'b1;
        end
    end
`else
    assign r_sym_err = 1'b0;
`endif

    assign bus.cpu_wr_ready = w_ready;
    assign bus.busy         = w_busy;
    assign bus.wr_en        = r_wr_en;
    assign bus.wr_addr      = r_wr_addr;
    assign bus.wr_data      = r_wr_data;
    assign bus.load_done    = r_load_done;
    assign bus.sym_err      = r_sym_err;

endmodule

// File: tb/tb_cpu_wr_ctrl.sv
// Directed bench for cpu_wr_ctrl with a 4-row frame (96 beats).
module tb_cpu_wr_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    cpu_wr_ctrl_if bus_if ();

    cpu_wr_ctrl #(
        .NUM_ROWS (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Write port after beat b of a frame carrying symbol value d
    task automatic chk_wr(input string tag, input int b, input int d);
        logic [31:0] en_exp;
        en_exp = 32'd1 << (b % 24);
        chk({tag, "_en"}, 32'(bus_if.wr_en), en_exp);
        chk({tag, "_addr"}, 32'(bus_if.wr_addr), 32'(b / 24));
        chk({tag, "_data"}, 32'(bus_if.wr_data), 32'(d));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"}, 32'(bus_if.wr_en), 32'd0);
        chk({tag, "_addr"}, 32'(bus_if.wr_addr), 32'd0);
        chk({tag, "_data"}, 32'(bus_if.wr_data), 32'd0);
        chk({tag, "_ready"}, 32'(bus_if.cpu_wr_ready), 32'd0);
        chk({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus_if.load_done), 32'd0);
        chk({tag, "_err"}, 32'(bus_if.sym_err), 32'd0);
    endtask

    initial begin
        int d;
        int exp_d;
        int exp_err;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_if.cpu_on       = 1'b0;
        bus_if.cpu_wr_valid = 1'b0;
        bus_if.cpu_wr_data  = '0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(bus_if.busy), 32'd0);

        // Scenario 1: full frame, valid always high
        bus_if.cpu_on       = 1'b1;
        bus_if.cpu_wr_valid = 1'b1;
        @(negedge clk);
        chk("s1_busy", 32'(bus_if.busy), 32'd1);
        chk("s1_ready", 32'(bus_if.cpu_wr_ready), 32'd1);
        chk("s1_noen", 32'(bus_if.wr_en), 32'd0);
        for (int b = 0; b < 96; b++) begin
            bus_if.cpu_wr_data = 9'(b);
            @(negedge clk);
            chk_wr("s1", b, b);
            chk("s1_done", 32'(bus_if.load_done), (b == 95) ? 32'd1 : 32'd0);
        end
        // Spot values from hand calculation
        chk("s1_last_en", 32'(bus_if.wr_en), 32'h0080_0000);
        chk("s1_last_addr", 32'(bus_if.wr_addr), 32'd3);

        // Scenario 4: hold in DONE with valid high
        for (int i = 0; i < 10; i++) begin
            bus_if.cpu_wr_data = 9'd500;
            #1;
            chk("s4_ready", 32'(bus_if.cpu_wr_ready), 32'd0);
            @(negedge clk);
            chk("s4_en", 32'(bus_if.wr_en), 32'd0);
            chk("s4_done", 32'(bus_if.load_done), 32'd0);
            chk("s4_busy", 32'(bus_if.busy), 32'd0);
        end
        bus_if.cpu_on = 1'b0;
        @(negedge clk);
        chk("s4_idle", 32'(bus_if.busy), 32'd0);
        bus_if.cpu_on = 1'b1;
        @(negedge clk);
        chk("s4_reload", 32'(bus_if.busy), 32'd1);

        // Scenario 2: valid toggles every other cycle
        for (int b = 0; b < 96; b++) begin
            bus_if.cpu_wr_valid = 1'b1;
            bus_if.cpu_wr_data  = 9'(b + 100);
            @(negedge clk);
            chk_wr("s2", b, b + 100);
            chk("s2_done", 32'(bus_if.load_done), (b == 95) ? 32'd1 : 32'd0);
            bus_if.cpu_wr_valid = 1'b0;
            @(negedge clk);
            chk("s2_gap_en", 32'(bus_if.wr_en), 32'd0);
            chk("s2_gap_addr", 32'(bus_if.wr_addr), 32'(b / 24));
            chk("s2_gap_data", 32'(bus_if.wr_data), 32'(b + 100));
            chk("s2_gap_done", 32'(bus_if.load_done), 32'd0);
        end
        bus_if.cpu_on = 1'b0;
        @(negedge clk);

        // Scenario 3: abort after 30 accepts
        bus_if.cpu_on       = 1'b1;
        bus_if.cpu_wr_valid = 1'b1;
        @(negedge clk);
        for (int b = 0; b < 30; b++) begin
            bus_if.cpu_wr_data = 9'(b + 200);
            @(negedge clk);
            chk_wr("s3", b, b + 200);
        end
        bus_if.cpu_on      = 1'b0;
        bus_if.cpu_wr_data = 9'd77;
        #1;
        chk("s3_abort_ready", 32'(bus_if.cpu_wr_ready), 32'd0);
        @(negedge clk);
        chk("s3_abort_en", 32'(bus_if.wr_en), 32'd0);
        chk("s3_abort_done", 32'(bus_if.load_done), 32'd0);
        chk("s3_abort_busy", 32'(bus_if.busy), 32'd0);
        chk("s3_abort_hold", 32'(bus_if.wr_data), 32'd229);
        bus_if.cpu_on = 1'b1;
        @(negedge clk);
        bus_if.cpu_wr_data = 9'd7;
        @(negedge clk);
        chk_wr("s3_restart", 0, 7);

        // Scenario 5: async reset after 50 accepts
        for (int b = 1; b < 50; b++) begin
            bus_if.cpu_wr_data = 9'(b);
            @(negedge clk);
            chk_wr("s5", b, b);
        end
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("s5_rst");
        bus_if.cpu_on = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s5_stay_idle", 32'(bus_if.busy), 32'd0);
            chk("s5_stay_ready", 32'(bus_if.cpu_wr_ready), 32'd0);
        end
        bus_if.cpu_on = 1'b1;
        @(negedge clk);
        chk("s5_load", 32'(bus_if.busy), 32'd1);

        // Scenario 6: out-of-range symbols
        for (int b = 0; b < 7; b++) begin
            d = (b == 5) ? 300 : ((b == 6) ? 256 : b);
`ifdef CPU_WR_SYM_CHK_EN
            exp_d   = (b == 5) ? 0 : d;
            exp_err = (b >= 5) ? 1 : 0;
`else
            exp_d   = d;
            exp_err = 0;
`endif
            bus_if.cpu_wr_data = 9'(d);
            @(negedge clk);
            chk_wr("s6", b, exp_d);
            chk("s6_err", 32'(bus_if.sym_err), 32'(exp_err));
        end
        bus_if.cpu_on = 1'b0;
        @(negedge clk);
        chk("s6_err_idle", 32'(bus_if.sym_err), 32'(exp_err));
        bus_if.cpu_on = 1'b1;
        @(negedge clk);
        chk("s6_err_clr", 32'(bus_if.sym_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_wr_ctrl.md
Name: cpu_wr_ctrl

Overview:
CPU-side write loader for the GF(257) 4x24 LDPC decoder. It is the write counterpart of the CPU read address generator.
- Accepts a valid/ready symbol stream from the CPU.
- Distributes symbols column-round-robin into the 24 column memories with one-hot write enables and a shared row address.
- Pulses load_done when a full frame is stored, so decoding can start.

Parameters:
ADDR_WIDTH, 8, row address width per column memory
DATA_WIDTH, 9, symbol width (GF(257) values 0..256)
NUM_COLS, 24, number of column memories
NUM_ROWS, 256, rows per column in one frame (2..2^ADDR_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cpu_on  in  1  level enable; high = load session active, low = abort/idle
cpu_wr_valid  in  1  CPU symbol valid
cpu_wr_data  in  DATA_WIDTH  CPU symbol
cpu_wr_ready  out  1  loader can accept a symbol
wr_en  out  NUM_COLS  one-hot column write enable
wr_addr  out  ADDR_WIDTH  shared row address
wr_data  out  DATA_WIDTH  write data
load_done  out  1  one-cycle pulse, frame complete
busy  out  1  high in LOAD
sym_err  out  1  sticky invalid-symbol flag (see Optional Feature)

Behaviour:
- Reset: state=IDLE; col_cnt=0, row_cnt=0. Outputs: cpu_wr_ready=0, wr_en=0, wr_addr=0, wr_data=0, load_done=0, busy=0, sym_err=0.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - cpu_wr_ready=0.
  - cpu_on=1 -> LOAD next cycle, with counters cleared and sym_err cleared.
- LOAD:
  - cpu_wr_ready=1 and busy=1, both combinational from state.
  - A beat is accepted when cpu_wr_valid & cpu_wr_ready.
  - On accept: col_cnt increments. At NUM_COLS-1, col_cnt wraps to 0 and row_cnt increments.
  - The accept of (col NUM_COLS-1, row NUM_ROWS-1) -> DONE.
  - valid low = hold; no counter change.
- DONE:
  - cpu_wr_ready=0. load_done=1 for exactly the first cycle in DONE.
  - Stays in DONE until cpu_on=0, then -> IDLE.
- Abort: cpu_on=0 in any state -> IDLE next cycle.
  - Counters are zeroed and load_done is not asserted.
  - A beat presented in the same cycle as cpu_on=0 is not accepted; ready is already forced low by cpu_on=0.
- Write port (registered, latency 1): for a beat accepted at cycle n, at cycle n+1:
  - wr_en = 1<<col_cnt(n)
  - wr_addr = row_cnt(n)
  - wr_data = cpu_wr_data(n)
  - In cycles with no accept, wr_en=0; wr_addr/wr_data hold their last values.
- The final write (last column, last row) and load_done are asserted in the same cycle.
- row_cnt never exceeds NUM_ROWS-1; no wrap beyond the frame. Extra valids in DONE are ignored (ready=0).
- Reset mid-LOAD: immediate asynchronous return to reset values. Partial frame contents in memory are don't-care.

Optional Feature:
Macro CPU_WR_SYM_CHK_EN.
- Defined:
  - A symbol > 256 accepted in LOAD sets sym_err, sticky until the next IDLE->LOAD transition or reset.
  - That symbol is written as 0.
- Undefined:
  - Symbols are written verbatim.
  - sym_err is tied to 0.

Decomposition:
- Shared package ldpc_pkg:
  - constants NUM_COLS=24 and GF_Q=257
  - the FSM state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2)
  - a symbol typedef of DATA_WIDTH bits
- One natural sub-module: cpu_wr_cnt, the col/row counter pair with wrap and last-beat flag. The FSM and write register stay in cpu_wr_ctrl.

Test Plan:
1. Full frame, NUM_ROWS=4, valid always high, data = beat index:
   - 96 accepts; beat 25 gives wr_en=bit1, wr_addr=1, wr_data=25.
   - load_done is a single pulse, coincident with wr_en=bit23, wr_addr=3.
   - cpu_wr_ready=0 afterwards.
2. Valid gaps: valid toggles every other cycle -> wr_en has no pulses in gap cycles; address sequence is identical to scenario 1; load_done after the 96th accept.
3. Abort: cpu_on dropped after 30 accepts -> IDLE, no load_done. Re-raising cpu_on restarts at col 0, row 0.
4. DONE hold: cpu_on kept high with valid high for 10 cycles after done -> no writes, no second load_done. cpu_on low then high -> new frame starts.
5. Async reset asserted mid-LOAD (after 50 accepts) -> all outputs are 0 within the same cycle; after release the loader stays in IDLE until cpu_on is high.
6. With CPU_WR_SYM_CHK_EN: data 300 at beat 5 -> wr_data=0 and sym_err=1 until the next session; data 256 leaves sym_err unchanged.
